data_mem_master: RTL and testbench
==================================

# data_mem_master

Initiator-side controller for the single-port data memory: accepts load/store burst requests from the processor datapath over a valid/ready handshake and drives the memory's `memRead`/`memWrite`/address/data pins one beat per cycle. Load data returns on a registered response stream with back-pressure. Store data is taken on a separate write-data stream. The block guarantees the memory never sees simultaneous read and write.

## Interface
- `DATA_WIDTH`, 19, memory word width
- `ADDR_WIDTH`, 19, word address width; addresses wrap modulo 2^ADDR_WIDTH
- `LEN_WIDTH`, 3, burst length field; beats = `reqLen`+1 (1..8)

- `clk` in 1, single clock; all state updates on rising edge
- `rst` in 1, synchronous, active-high reset
- `reqValid` in 1, request present
- `reqReady` out 1, request accepted when `reqValid`&&`reqReady`
- `reqWrite` in 1, 1=store burst, 0=load burst
- `reqAddr` in ADDR_WIDTH, base word address
- `reqLen` in LEN_WIDTH, beats minus one
- `wrData` in DATA_WIDTH, store beat data
- `wrValid` in 1, store beat present
- `wrReady` out 1, store beat consumed when `wrValid`&&`wrReady`
- `rspData` out DATA_WIDTH, load beat data (registered)
- `rspValid` out 1, load beat present
- `rspLast` out 1, marks final beat of a load burst
- `rspReady` in 1, load beat consumed when `rspValid`&&`rspReady`
- `memAddress` out ADDR_WIDTH, to memory `address`
- `memDataIn` out DATA_WIDTH, to memory `dataIn`
- `memRead` out 1, to memory `memRead`
- `memWrite` out 1, to memory `memWrite`
- `memDataOut` in DATA_WIDTH, from memory `dataOut`, combinational read result
- `busy` out 1, high whenever state is not IDLE

## Operation
- States: IDLE, READ, WRITE. Registers: base address, beat counter (LEN_WIDTH), last-beat index, response slot (`rspData`/`rspValid`/`rspLast`).
- IDLE: `reqReady`=1. On accept, latch `reqAddr`/`reqLen`, clear the beat counter, and go to READ or WRITE per `reqWrite`.
- READ: a beat fires when `!rspValid || rspReady`. While the beat fires: `memRead`=1, `memAddress`=base+beat. At the edge, `memDataOut` goes into the slot, `rspValid`=1, and `rspLast`=(beat==last). The beat counter then increments. Firing the last beat returns the FSM to IDLE. When the beat does not fire, `memRead`=0.
- Slot drains when `rspReady`&&`rspValid` and no new beat fires. Drain and fill in the same cycle are allowed and keep `rspValid`=1.
- WRITE: `wrReady`=1. When `wrValid`=1, drive `memWrite`=1, `memAddress`=base+beat and `memDataIn`=`wrData`; the memory commits at that edge. Counter increments. The last beat returns the FSM to IDLE. Writes produce no response.
- `wrReady`=0 outside WRITE. `wrValid` in other states is ignored.
- Address arithmetic is ADDR_WIDTH-bit unsigned: 0x7FFFF+1 wraps to 0x00000.
- Invariant: `memRead`&&`memWrite` never both 1. `memWrite`=0 outside WRITE; `memRead`=0 outside READ.
- Idle memory outputs: `memAddress`=0, `memDataIn`=0.

## Timing
- Reset values: state IDLE, `reqReady`=1 (after reset), `rspValid`=0, `rspLast`=0, `rspData`=0, `wrReady`=0, `memRead`=0, `memWrite`=0, `busy`=0.
- Load latency: request accepted at edge T, first beat reads in cycle T+1, and `rspValid` rises after edge T+1. With `rspReady` held high, throughput is 1 beat/cycle: an N-beat burst occupies N cycles after accept.
- Store: first `wrReady` in the cycle after accept. The memory write lands at the edge where `wrValid`&&`wrReady`.
- A new request can be accepted in the cycle after the last beat. A pending final response in the slot does not block acceptance; the next READ's first beat waits for the slot.
- `rst` mid-burst: abort the burst, go to IDLE, and discard any pending response. Memory words already written stay written. Remaining store beats are not consumed.

## Structure
- Shared package `data_mem_pkg`: `ADDR_WIDTH`/`DATA_WIDTH`/`LEN_WIDTH` defaults, and the state enum (IDLE, READ, WRITE).
- No sub-module is needed. The FSM, counter and single response slot live in one module. The data memory itself is instantiated alongside this block at top level.

## Test plan
- Reset, then a single store to address 0x00010 with data 0x12345, then a single load of 0x00010. Required: `memWrite` pulses for one cycle; `rspData`=0x12345 with `rspValid` and `rspLast`=1 two edges after load accept.
- 8-beat store to 0x00100 with data 0x1..0x8, then an 8-beat load with `rspReady`=1. Required: 8 consecutive responses 0x1..0x8; `rspLast` only on the 8th; `busy` high exactly 8 cycles per burst.
- 4-beat load with `rspReady` toggling 1,0,0,1,…. Required: no beat is lost or duplicated; `memRead` is asserted only in cycles where a beat is captured.
- 3-beat store at 0x7FFFF. Required: writes go to 0x7FFFF, 0x00000 and 0x00001; a load-back returns them in order.
- Assert `rst` during beat 2 of a 6-beat load. Required: the next cycle has `rspValid`=0, `busy`=0 and `reqReady`=1. The monitor checks throughout that `memRead`&&`memWrite` is never true.

Source files
------------

// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared widths and FSM state encoding for the data memory master
package data_mem_pkg;

    localparam int DEFAULT_DATA_WIDTH = 19;
    localparam int DEFAULT_ADDR_WIDTH = 19;
    localparam int DEFAULT_LEN_WIDTH  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

endpackage

// File: rtl/data_mem_master.sv
// rtl/data_mem_master.sv - burst load/store initiator driving a single-port data memory
module data_mem_master
    import data_mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int LEN_WIDTH  = DEFAULT_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic                  reqWrite,
    input  logic [ADDR_WIDTH-1:0] reqAddr,
    input  logic [LEN_WIDTH-1:0]  reqLen,
    input  logic [DATA_WIDTH-1:0] wrData,
    input  logic                  wrValid,
    output logic                  wrReady,
    output logic [DATA_WIDTH-1:0] rspData,
    output logic                  rspValid,
    output logic                  rspLast,
    input  logic                  rspReady,
    output logic [ADDR_WIDTH-1:0] memAddress,
    output logic [DATA_WIDTH-1:0] memDataIn,
    output logic                  memRead,
    output logic                  memWrite,
    input  logic [DATA_WIDTH-1:0] memDataOut,
    output logic                  busy
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [LEN_WIDTH-1:0]  beat_q, beat_d;
    logic [LEN_WIDTH-1:0]  last_q, last_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_last_q, rsp_last_d;

    logic [ADDR_WIDTH-1:0] beat_addr;
    logic                  is_last_beat;
    logic                  slot_free;

    assign beat_addr    = base_q + ADDR_WIDTH'(beat_q);
    assign is_last_beat = (beat_q == last_q);
    // A load beat may only be issued when its result has somewhere to land.
    assign slot_free    = !rsp_valid_q || rspReady;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        beat_d      = beat_q;
        last_d      = last_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        rsp_last_d  = rsp_last_q;
        reqReady    = 1'b0;
        wrReady     = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        memAddress  = '0;
        memDataIn   = '0;

        if (rsp_valid_q && rspReady) begin
            rsp_valid_d = 1'b0;
            rsp_last_d  = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                reqReady = 1'b1;
                if (reqValid) begin
                    base_d  = reqAddr;
                    last_d  = reqLen;
                    beat_d  = '0;
                    state_d = reqWrite ? ST_WRITE : ST_READ;
                end
            end
            ST_READ: begin
                if (slot_free) begin
                    memRead     = 1'b1;
                    memAddress  = beat_addr;
                    rsp_data_d  = memDataOut;
                    rsp_valid_d = 1'b1;
                    rsp_last_d  = is_last_beat;
                    beat_d      = beat_q + LEN_WIDTH'(1);
                    if (is_last_beat) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WRITE: begin
                wrReady = 1'b1;
                if (wrValid) begin
                    memWrite   = 1'b1;
                    memAddress = beat_addr;
                    memDataIn  = wrData;
                    beat_d     = beat_q + LEN_WIDTH'(1);
                    if (is_last_beat) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            beat_q      <= '0;
            last_q      <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            beat_q      <= beat_d;
            last_q      <= last_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

    assign rspData  = rsp_data_q;
    assign rspValid = rsp_valid_q;
    assign rspLast  = rsp_last_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_data_mem_master.sv
// tb/tb_data_mem_master.sv - self-checking bench for data_mem_master with a sparse memory model
module tb_data_mem_master;

    localparam int AW = 19;
    localparam int DW = 19;
    localparam int LW = 3;

    logic          clk;
    logic          rst;
    logic          reqValid;
    logic          reqReady;
    logic          reqWrite;
    logic [AW-1:0] reqAddr;
    logic [LW-1:0] reqLen;
    logic [DW-1:0] wrData;
    logic          wrValid;
    logic          wrReady;
    logic [DW-1:0] rspData;
    logic          rspValid;
    logic          rspLast;
    logic          rspReady;
    logic [AW-1:0] memAddress;
    logic [DW-1:0] memDataIn;
    logic          memRead;
    logic          memWrite;
    logic [DW-1:0] memDataOut;
    logic          busy;

    data_mem_master #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .LEN_WIDTH (LW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .reqValid  (reqValid),
        .reqReady  (reqReady),
        .reqWrite  (reqWrite),
        .reqAddr   (reqAddr),
        .reqLen    (reqLen),
        .wrData    (wrData),
        .wrValid   (wrValid),
        .wrReady   (wrReady),
        .rspData   (rspData),
        .rspValid  (rspValid),
        .rspLast   (rspLast),
        .rspReady  (rspReady),
        .memAddress(memAddress),
        .memDataIn (memDataIn),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .memDataOut(memDataOut),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Test addresses are chosen so their low 10 bits never collide.
    logic [DW-1:0] mem [0:1023];
    assign memDataOut = mem[memAddress[9:0]];
    always @(posedge clk) begin
        if (memWrite) mem[memAddress[9:0]] <= memDataIn;
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } rsp_t;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic [DW-1:0] d0;
        logic [3:0]    pat;
        int            exp_busy;
    } vec_t;

    wr_t           wr_q [$];
    rsp_t          rsp_q [$];
    logic [DW-1:0] exp_mem [int];
    vec_t          vecs [7];

    int checks = 0;
    int errors = 0;
    int busy_cnt = 0;
    int wr_cnt = 0;
    wr_t  mon_w;
    rsp_t mon_r;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("rd_wr_exclusive", 32'(memRead && memWrite), 32'h0);
            chk("read_into_full_slot", 32'(memRead && rspValid && !rspReady), 32'h0);
            if (busy) busy_cnt++;
            if (memWrite) begin
                wr_cnt++;
                chk("write_expected", 32'(wr_q.size() != 0), 32'h1);
                if (wr_q.size() != 0) begin
                    mon_w = wr_q.pop_front();
                    chk("wr_addr", 32'(memAddress), 32'(mon_w.addr));
                    chk("wr_data", 32'(memDataIn), 32'(mon_w.data));
                end
            end
            if (rspValid && rspReady) begin
                chk("rsp_expected", 32'(rsp_q.size() != 0), 32'h1);
                if (rsp_q.size() != 0) begin
                    mon_r = rsp_q.pop_front();
                    chk("rsp_data", 32'(rspData), 32'(mon_r.data));
                    chk("rsp_last", 32'(rspLast), 32'(mon_r.last));
                end
            end
        end
    end

    task automatic wait_accept();
        int n = 0;
        reqValid = 1'b1;
        @(negedge clk);
        while (!reqReady && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_accept", 32'(reqReady), 32'h1);
        @(posedge clk);
        #1;
        reqValid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(busy), 32'h0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [AW-1:0] addr, input logic [LW-1:0] len,
                            input logic [DW-1:0] d0, input int exp_busy);
        logic [AW-1:0] a;
        int n;
        for (int i = 0; i <= int'(len); i++) begin
            a = addr + AW'(i);
            wr_q.push_back('{addr: a, data: d0 + DW'(i)});
            exp_mem[int'(a)] = d0 + DW'(i);
        end
        busy_cnt = 0;
        reqWrite = 1'b1;
        reqAddr  = addr;
        reqLen   = len;
        wrValid  = 1'b1;
        wrData   = d0;
        wait_accept();
        for (int i = 0; i <= int'(len); i++) begin
            wrData = d0 + DW'(i);
            n = 0;
            @(negedge clk);
            while (!wrReady && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("wr_ready_seen", 32'(wrReady), 32'h1);
            @(posedge clk);
            #1;
        end
        wrValid = 1'b0;
        wait_idle("store_idle");
        chk("store_drained", 32'(wr_q.size()), 32'h0);
        if (exp_busy != 0) chk("store_busy_cycles", 32'(busy_cnt), 32'(exp_busy));
    endtask

    task automatic do_load(input logic [AW-1:0] addr, input logic [LW-1:0] len,
                           input logic [3:0] pat, input int exp_busy);
        logic [AW-1:0] a;
        int k = 1;
        int n = 0;
        for (int i = 0; i <= int'(len); i++) begin
            a = addr + AW'(i);
            rsp_q.push_back('{data: exp_mem[int'(a)], last: (i == int'(len))});
        end
        busy_cnt = 0;
        reqWrite = 1'b0;
        reqAddr  = addr;
        reqLen   = len;
        rspReady = pat[0];
        wait_accept();
        while (n < 200) begin
            rspReady = pat[k % 4];
            k++;
            n++;
            @(negedge clk);
            if (rsp_q.size() == 0 && !busy) break;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        rspReady = 1'b1;
        chk("load_drained", 32'(rsp_q.size()), 32'h0);
        if (exp_busy != 0) chk("load_busy_cycles", 32'(busy_cnt), 32'(exp_busy));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        vecs[0] = '{wr: 1'b1, addr: 19'h00100, len: 3'd7, d0: 19'h00001, pat: 4'b1111, exp_busy: 8};
        vecs[1] = '{wr: 1'b0, addr: 19'h00100, len: 3'd7, d0: 19'h00000, pat: 4'b1111, exp_busy: 8};
        vecs[2] = '{wr: 1'b0, addr: 19'h00100, len: 3'd3, d0: 19'h00000, pat: 4'b1001, exp_busy: 0};
        vecs[3] = '{wr: 1'b1, addr: 19'h7FFFF, len: 3'd2, d0: 19'h0AAAA, pat: 4'b1111, exp_busy: 3};
        vecs[4] = '{wr: 1'b0, addr: 19'h7FFFF, len: 3'd2, d0: 19'h00000, pat: 4'b1111, exp_busy: 3};
        vecs[5] = '{wr: 1'b0, addr: 19'h00100, len: 3'd7, d0: 19'h00000, pat: 4'b0101, exp_busy: 0};
        vecs[6] = '{wr: 1'b0, addr: 19'h00010, len: 3'd0, d0: 19'h00000, pat: 4'b0011, exp_busy: 0};

        rst      = 1'b1;
        reqValid = 1'b0;
        reqWrite = 1'b0;
        reqAddr  = '0;
        reqLen   = '0;
        wrData   = '0;
        wrValid  = 1'b0;
        rspReady = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_reqReady", 32'(reqReady), 32'h1);
        chk("reset_rspValid", 32'(rspValid), 32'h0);
        chk("reset_rspLast", 32'(rspLast), 32'h0);
        chk("reset_rspData", 32'(rspData), 32'h0);
        chk("reset_wrReady", 32'(wrReady), 32'h0);
        chk("reset_memRead", 32'(memRead), 32'h0);
        chk("reset_memWrite", 32'(memWrite), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_memAddress", 32'(memAddress), 32'h0);
        @(posedge clk);
        #1;

        wr_cnt = 0;
        do_store(19'h00010, 3'd0, 19'h12345, 1);
        chk("single_store_pulse", 32'(wr_cnt), 32'h1);

        rsp_q.push_back('{data: 19'h12345, last: 1'b1});
        reqWrite = 1'b0;
        reqAddr  = 19'h00010;
        reqLen   = 3'd0;
        rspReady = 1'b1;
        wait_accept();
        @(posedge clk);
        @(negedge clk);
        chk("single_load_valid", 32'(rspValid), 32'h1);
        chk("single_load_last", 32'(rspLast), 32'h1);
        chk("single_load_data", 32'(rspData), 32'h12345);
        @(posedge clk);
        #1;
        wait_idle("single_load_idle");

        for (int v = 0; v < 7; v++) begin
            if (vecs[v].wr) do_store(vecs[v].addr, vecs[v].len, vecs[v].d0, vecs[v].exp_busy);
            else            do_load(vecs[v].addr, vecs[v].len, vecs[v].pat, vecs[v].exp_busy);
        end

        chk("wrap_mem_7ffff", 32'(mem[10'h3FF]), 32'h0AAAA);
        chk("wrap_mem_00000", 32'(mem[10'h000]), 32'h0AAAB);
        chk("wrap_mem_00001", 32'(mem[10'h001]), 32'h0AAAC);

        reqWrite = 1'b0;
        reqAddr  = 19'h00100;
        reqLen   = 3'd5;
        rspReady = 1'b1;
        wait_accept();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rsp_q.delete();
        @(negedge clk);
        chk("abort_rspValid", 32'(rspValid), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_reqReady", 32'(reqReady), 32'h1);
        @(posedge clk);
        #1;

        do_load(19'h00010, 3'd0, 4'b1111, 1);
        do_store(19'h00200, 3'd1, 19'h7FFFF, 2);
        do_load(19'h00200, 3'd1, 4'b1111, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
